// File: rtl/song_sequencer_if.sv
// Song ROM bus: the sequencer drives {song_id, note_idx} and the ROM
// answers with the note word one clock later.
interface song_sequencer_if #(
   parameter int ADDR_W = 6
);
   logic [2+ADDR_W:0] rom_addr;
   logic [21:0]       rom_data;

   modport master (output rom_addr, input  rom_data);
   modport slave  (input  rom_addr, output rom_data);
endinterface

// File: rtl/song_sequencer.sv
// Playback controller: walks the song ROM on the beat tick, handles
// pause/next/select/auto-advance and inserts a silent gap between untied notes.
module song_sequencer #(
   parameter int ADDR_W     = 6,
   parameter int GAP_CYCLES = 400000,
   parameter int GAP_W      = 19
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             beat_tick,
   input  logic             pause_press,
   input  logic             next_press,
   input  logic [2:0]       song_sel,
   song_sequencer_if.master rom,
   output logic [19:0]      note_div,
   output logic             playing,
   output logic [2:0]       song_id
);

   typedef enum logic [2:0] {
      S_PAUSE,
      S_FETCH,
      S_LATCH,
      S_GAP,
      S_PLAY
   } state_t;

   // Counter runs from GAP_CYCLES-1 down to 0, giving exactly GAP_CYCLES cycles in GAP.
   localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

   state_t              state_q,      state_d;
   logic [2:0]          song_id_q,    song_id_d;
   logic [ADDR_W-1:0]   note_idx_q,   note_idx_d;
   logic [2:0]          song_sel_q,   song_sel_d;
   logic                beat_pend_q,  beat_pend_d;
   logic [19:0]         cur_div_q,    cur_div_d;
   logic                cur_last_q,   cur_last_d;
   logic                cur_tie_q,    cur_tie_d;
   logic [GAP_W-1:0]    gap_cnt_q,    gap_cnt_d;
   logic [19:0]         note_div_q,   note_div_d;
   logic                playing_q,    playing_d;

   logic                sel_chg;

   always_comb begin
      // NOTE: every _d gets a hold default first so no path leaves it unassigned (no latches).
      state_d     = state_q;
      song_id_d   = song_id_q;
      note_idx_d  = note_idx_q;
      song_sel_d  = song_sel;
      beat_pend_d = beat_pend_q;
      cur_div_d   = cur_div_q;
      cur_last_d  = cur_last_q;
      cur_tie_d   = cur_tie_q;
      gap_cnt_d   = gap_cnt_q;

      sel_chg = (song_sel != song_sel_q);

      if (pause_press) begin
         state_d     = (state_q == S_PAUSE) ? S_FETCH : S_PAUSE;
         beat_pend_d = 1'b0;
         // A song change still moves the position even though pause wins.
         if (sel_chg) begin
            song_id_d  = song_sel;
            note_idx_d = '0;
         end
      end else if (sel_chg || next_press) begin
         song_id_d   = sel_chg ? song_sel : song_id_q + 3'd1;
         note_idx_d  = '0;
         beat_pend_d = 1'b0;
         if (state_q != S_PAUSE) state_d = S_FETCH;
      end else begin
         unique case (state_q)
            S_PAUSE: begin
               if (beat_tick) beat_pend_d = 1'b0;
            end
            S_FETCH: begin
               if (beat_tick) beat_pend_d = 1'b1;
               state_d = S_LATCH;
            end
            S_LATCH: begin
               if (beat_tick) beat_pend_d = 1'b1;
               cur_div_d  = rom.rom_data[19:0];
               cur_last_d = rom.rom_data[20];
               cur_tie_d  = rom.rom_data[21];
               gap_cnt_d  = GAP_LOAD;
               state_d    = (!rom.rom_data[21] && GAP_CYCLES > 0) ? S_GAP : S_PLAY;
            end
            S_GAP: begin
               if (beat_tick) beat_pend_d = 1'b1;
               if (gap_cnt_q == '0) state_d = S_PLAY;
               else                 gap_cnt_d = gap_cnt_q - 1'b1;
            end
            S_PLAY: begin
               // A beat that arrived while fetching/gapping advances on the first PLAY cycle.
               if (beat_tick || beat_pend_q) begin
                  beat_pend_d = 1'b0;
                  state_d     = S_FETCH;
                  if (cur_last_q) begin
                     note_idx_d = '0;
                     song_id_d  = song_id_q + 3'd1;
                  end else begin
                     note_idx_d = note_idx_q + 1'b1;
                  end
               end
            end
            default: state_d = S_PAUSE;
         endcase
      end

      // Outputs are registered from the next state so they line up with it.
      note_div_d = (state_d == S_PLAY) ? cur_div_d : '0;
      playing_d  = (state_d != S_PAUSE);
   end

   // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_PAUSE;
         song_id_q   <= '0;
         note_idx_q  <= '0;
         song_sel_q  <= '0;
         beat_pend_q <= 1'b0;
         cur_div_q   <= '0;
         cur_last_q  <= 1'b0;
         cur_tie_q   <= 1'b0;
         gap_cnt_q   <= '0;
         note_div_q  <= '0;
         playing_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         song_id_q   <= song_id_d;
         note_idx_q  <= note_idx_d;
         song_sel_q  <= song_sel_d;
         beat_pend_q <= beat_pend_d;
         cur_div_q   <= cur_div_d;
         cur_last_q  <= cur_last_d;
         cur_tie_q   <= cur_tie_d;
         gap_cnt_q   <= gap_cnt_d;
         note_div_q  <= note_div_d;
         playing_q   <= playing_d;
      end
   end

   assign rom.rom_addr = {song_id_q, note_idx_q};
   assign note_div     = note_div_q;
   assign playing      = playing_q;
   assign song_id      = song_id_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with GAP_CYCLES=4, ADDR_W=3 and a
// small synchronous song ROM model.
module tb_song_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        beat_tick = 1'b0;
   logic        pause_press = 1'b0;
   logic        next_press = 1'b0;
   logic [2:0]  song_sel = 3'd0;
   logic [19:0] note_div;
   logic        playing;
   logic [2:0]  song_id;
   logic [21:0] rom_q;

   int total = 0;
   int bad   = 0;

   song_sequencer_if #(.ADDR_W(3)) rom_if ();

   song_sequencer #(.ADDR_W(3), .GAP_CYCLES(4), .GAP_W(3)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .beat_tick   (beat_tick),
      .pause_press (pause_press),
      .next_press  (next_press),
      .song_sel    (song_sel),
      .rom         (rom_if.master),
      .note_div    (note_div),
      .playing     (playing),
      .song_id     (song_id)
   );

   always #5 clk = ~clk;

   // ROM word = {tie, last, div}. Unlisted entries: div = song*1000 + idx, untied, not last.
   function automatic logic [21:0] rom_word(input logic [5:0] a);
      case (a)
         6'd0:    return {1'b0, 1'b0, 20'd100};
         6'd1:    return {1'b1, 1'b0, 20'd200};
         6'd2:    return {1'b0, 1'b1, 20'd300};
         6'd8:    return {1'b0, 1'b1, 20'd500};
         6'd56:   return {1'b0, 1'b1, 20'd700};
         default: return {2'b00, 20'(int'(a[5:3]) * 1000 + int'(a[2:0]))};
      endcase
   endfunction

   always @(posedge clk) rom_q <= rom_word(rom_if.rom_addr);
   assign rom_if.rom_data = rom_q;

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat();
      beat_tick = 1'b1;
      tick();
      beat_tick = 1'b0;
   endtask

   task automatic pause();
      pause_press = 1'b1;
      tick();
      pause_press = 1'b0;
   endtask

   // Wait (bounded) for the next sounding note and compare its divider.
   task automatic wait_note(input string tag, input int exp);
      for (int i = 0; i < 20; i++) begin
         tick();
         if (note_div != 0) break;
      end
      check(tag, int'(note_div), exp);
   endtask

   initial begin
      #3;
      check("rst_note_div", int'(note_div), 0);
      check("rst_playing", int'(playing), 0);
      check("rst_rom_addr", int'(rom_if.rom_addr), 0);
      check("rst_song_id", int'(song_id), 0);
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      check("idle_playing", int'(playing), 0);

      // Start: FETCH at T+1, silent through GAP, first note at T+7.
      pause();
      check("start_rom_addr", int'(rom_if.rom_addr), 0);
      check("start_playing", int'(playing), 1);
      check("start_div_t1", int'(note_div), 0);
      for (int i = 2; i <= 6; i++) begin
         tick();
         check($sformatf("start_div_t%0d", i), int'(note_div), 0);
      end
      tick();
      check("start_div_t7", int'(note_div), 100);

      // Beat into a tied note: no gap, note at B+3.
      beat();
      check("tie_div_b1", int'(note_div), 0);
      check("tie_addr_b1", int'(rom_if.rom_addr), 1);
      tick();
      check("tie_div_b2", int'(note_div), 0);
      tick();
      check("tie_div_b3", int'(note_div), 200);

      beat();
      wait_note("note_300", 300);
      beat();
      check("adv_song1_id", int'(song_id), 1);
      check("adv_song1_addr", int'(rom_if.rom_addr), 8);
      wait_note("note_500", 500);

      beat();
      check("adv_song2_id", int'(song_id), 2);
      check("adv_song2_addr", int'(rom_if.rom_addr), 16);
      wait_note("note_2000", 2000);
      for (int i = 1; i <= 7; i++) begin
         beat();
         wait_note($sformatf("song2_idx%0d", i), 2000 + i);
      end
      beat();
      check("wrap_addr", int'(rom_if.rom_addr), 16);
      check("wrap_song_id", int'(song_id), 2);
      wait_note("wrap_note", 2000);

      // Song 7 last note wraps to song 0.
      song_sel = 3'd7;
      tick();
      check("sel7_id", int'(song_id), 7);
      wait_note("note_700", 700);
      beat();
      check("song7_wrap_id", int'(song_id), 0);
      check("song7_wrap_addr", int'(rom_if.rom_addr), 0);
      wait_note("note_100_again", 100);

      // Pause mid-note, ignore beats, resume replays the same note.
      beat();
      wait_note("note_200_again", 200);
      pause();
      check("pause_div", int'(note_div), 0);
      check("pause_playing", int'(playing), 0);
      for (int i = 0; i < 3; i++) begin
         beat();
         tick();
      end
      check("pause_addr_held", int'(rom_if.rom_addr), 1);
      pause();
      check("resume_addr", int'(rom_if.rom_addr), 1);
      check("resume_playing", int'(playing), 1);
      tick();
      tick();
      check("resume_div", int'(note_div), 200);

      // Beat during GAP: 300 held for one cycle then advance to song 1.
      beat();
      tick();
      tick();
      tick();
      beat_tick = 1'b1;
      tick();
      beat_tick = 1'b0;
      tick();
      tick();
      check("gapbeat_div_b7", int'(note_div), 300);
      tick();
      check("gapbeat_div_b8", int'(note_div), 0);
      check("gapbeat_song_id", int'(song_id), 1);
      check("gapbeat_addr", int'(rom_if.rom_addr), 8);
      wait_note("gapbeat_500", 500);

      // Pause + next + select in one cycle: pause wins, select still moves position.
      pause_press = 1'b1;
      next_press  = 1'b1;
      song_sel    = 3'd5;
      tick();
      pause_press = 1'b0;
      next_press  = 1'b0;
      check("simul_playing", int'(playing), 0);
      check("simul_song_id", int'(song_id), 5);
      check("simul_addr", int'(rom_if.rom_addr), 40);
      check("simul_div", int'(note_div), 0);
      next_press = 1'b1;
      tick();
      next_press = 1'b0;
      tick();
      check("pnext_song_id", int'(song_id), 6);
      check("pnext_addr", int'(rom_if.rom_addr), 48);
      check("pnext_playing", int'(playing), 0);

      // Async reset while in GAP.
      pause();
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("areset_div", int'(note_div), 0);
      check("areset_playing", int'(playing), 0);
      check("areset_addr", int'(rom_if.rom_addr), 0);
      check("areset_song_id", int'(song_id), 0);
      tick();
      rst_n = 1'b1;
      tick();
      check("rel_sel_song_id", int'(song_id), 5);
      check("rel_sel_playing", int'(playing), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/song_sequencer.md
# song_sequencer

Playback controller for the music path. It walks a song ROM note by note on the 8 Hz beat tick and handles pause/resume, next-song, song-select and auto-advance. It inserts a short silent gap between non-tied notes and drives `note_div` straight into `buzzer_control`. It replaces the pause/song logic between `fsm`, `music_player` and the buzzer.

## Interface

Parameters:
- `ADDR_W`, default 6: note index width; each song holds at most 2^ADDR_W notes.
- `GAP_CYCLES`, default 400000: silent articulation gap in clk cycles (10 ms at 40 MHz). A value of 0 disables the gap.
- `GAP_W`, default 19: gap counter width; must hold GAP_CYCLES.

Ports:
- `clk` in 1: 40 MHz system clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `beat_tick` in 1: one-cycle pulse per beat slot (8 Hz).
- `pause_press` in 1: one-cycle pulse from debounce/one_pulse; toggles pause.
- `next_press` in 1: one-cycle pulse; skip to the next song.
- `song_sel` in 3: requested song; any change restarts playback at that song.
- `rom_addr` out 3+ADDR_W: {song_id, note_idx} to the song ROM.
- `rom_data` in 22: [19:0] note divider (0 = rest), [20] last note of song, [21] tie (no gap before this note). Valid one cycle after `rom_addr`.
- `note_div` out 20: divider to `buzzer_control`; 0 = silence.
- `playing` out 1: 1 when not paused.
- `song_id` out 3: current song.

## Operation

States:
- PAUSE
- FETCH: drive `rom_addr`.
- LATCH: register `rom_data` into cur_div, cur_last, cur_tie.
- GAP: `note_div` = 0 while the counter runs.
- PLAY: `note_div` = cur_div.

Transitions:
- PAUSE: `pause_press` → FETCH. `song_id` and `note_idx` are kept, so the current note replays.
- FETCH → LATCH unconditionally.
- LATCH → GAP if cur_tie = 0 and GAP_CYCLES > 0. Otherwise LATCH → PLAY.
- GAP → PLAY after exactly GAP_CYCLES cycles in GAP.
- PLAY, on beat (see below):
  - If cur_last: `note_idx` ← 0 and `song_id` ← `song_id`+1 (mod 8, 7→0).
  - Else: `note_idx` ← `note_idx`+1, wrapping to 0 within the same song at 2^ADDR_W−1.
  - Then → FETCH.
- `pause_press` in FETCH, LATCH, GAP or PLAY → PAUSE. `note_idx` is kept and cur_* is discarded.

Song change:
- A song change is `song_sel` ≠ song_sel_q, where song_sel_q is `song_sel` registered every cycle.
- On a song change: `song_id` ← `song_sel`, `note_idx` ← 0.
- `next_press`: `song_id` ← `song_id`+1 (mod 8), `note_idx` ← 0.
- Either event in a playing state → FETCH. In PAUSE the state stays PAUSE and only the position updates.

Beat handling:
- A `beat_tick` during FETCH, LATCH or GAP sets beat_pend.
- On entry to PLAY with beat_pend = 1, the advance happens on the first PLAY cycle and beat_pend clears.
- `beat_tick` in PAUSE is ignored and clears beat_pend.

Simultaneous events (priority high→low): `pause_press`, song_sel change, `next_press`, `beat_tick`. Losing events in the same cycle are dropped, except that a song change always updates the position even when `pause_press` wins.

`note_div` is registered:
- It equals cur_div in every cycle the state is PLAY.
- It is 0 in all other states.

## Timing

Reset values:
- state = PAUSE; `note_div` = 0; `playing` = 0.
- `song_id` = 0, `note_idx` = 0, so `rom_addr` = 0.
- song_sel_q = 0 and beat_pend = 0.

A nonzero `song_sel` at reset release counts as a change one cycle later. In PAUSE it only loads `song_id`.

`pause_press` at cycle T:
- FETCH at T+1, with `rom_addr` valid in the same cycle.
- LATCH at T+2.
- GAP from T+3 to T+2+GAP_CYCLES.
- First nonzero `note_div` at T+3+GAP_CYCLES; with a tied note, at T+3.

`beat_tick` at cycle B while in PLAY:
- FETCH at B+1.
- `note_div` = 0 from B+1.
- The new note appears at B+3+GAP_CYCLES (B+3 if tied).

`playing` changes one cycle after the `pause_press` edge.

Asynchronous reset mid-note forces all outputs to their reset values immediately.

## Test plan

Use GAP_CYCLES=4 and ADDR_W=3. ROM song 0 holds divs 100, 200 (tie), 300 (last); song 1 holds div 500 (last).

- Reset, then `pause_press` at T → `rom_addr`=0 at T+1, `note_div`=0 for T+1..T+6, `note_div`=100 at T+7, `playing`=1 from T+1.
- Beat at B in note 0 → `note_div`=0 at B+1..B+2, `note_div`=200 at B+3 (tied, no gap). Beat on note 300 → `song_id`=1, `rom_addr`={1,0}, then `note_div`=500.
- Beat on song 1's last note → `song_id`=2. Beat on song 7's last note → `song_id`=0. An index reaching 7 without the last flag wraps to 0 with `song_id` unchanged.
- `pause_press` during PLAY → `note_div`=0 next cycle, beats ignored, `note_idx` held. A second `pause_press` refetches the same `rom_addr`.
- `beat_tick` during GAP → advance on the first PLAY cycle; the held note lasts 1 cycle.
- Same cycle `pause_press`, `next_press`, `song_sel`=5 while playing → PAUSE, `song_id`=5, `note_idx`=0. `next_press` while paused → `song_id`=6, still paused.
- Assert `rst_n` low during GAP → `note_div`=0, `playing`=0, `rom_addr`=0 before the next clock edge.
